// File: rtl/stat_info_mem_mp.sv
// Multi-port statistics counter bank: round-robin update arbiter, CPU read port and a
// 2-stage read-modify-write pipeline with write-back bypass over a self-clearing counter RAM.
module stat_info_mem_mp #(
  parameter int STAT_CNT   = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int CNT_WIDTH  = 32,
  parameter int INC_WIDTH  = 8,
  parameter int REQ_PORTS  = 2,
  parameter int SAT_MODE   = 0,
  parameter int RD_CLEAR   = 0
) (
  input  logic                            Clock,
  input  logic                            nReset,
  input  logic [REQ_PORTS-1:0]            qvUpdtReq,
  input  logic [REQ_PORTS*ADDR_WIDTH-1:0] qvUpdtIndex,
  input  logic [REQ_PORTS*INC_WIDTH-1:0]  qvUpdtNum,
  input  logic [REQ_PORTS-1:0]            qvUpdtClr,
  output logic [REQ_PORTS-1:0]            qvUpdtAck,
  input  logic                            qStatREn,
  input  logic [ADDR_WIDTH-1:0]           qvStatRAddr,
  output logic                            qStatRValid,
  output logic [CNT_WIDTH-1:0]            qvStatRData,
  output logic                            qInitDone
);

  localparam int PTR_W  = (REQ_PORTS > 1) ? $clog2(REQ_PORTS) : 1;
  localparam int MEM_AW = (STAT_CNT > 1) ? $clog2(STAT_CNT) : 1;
  localparam int INIT_W = $clog2(STAT_CNT + 1);

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] old_v,
                                                   input logic [INC_WIDTH-1:0] num_v,
                                                   input logic clr_v);
    logic [CNT_WIDTH:0] sum;
    sum = {1'b0, old_v} + {{(CNT_WIDTH + 1 - INC_WIDTH){1'b0}}, num_v};
    if (clr_v) return '0;
    if ((SAT_MODE != 0) && sum[CNT_WIDTH]) return '1;
    return sum[CNT_WIDTH-1:0];
  endfunction

  logic [CNT_WIDTH-1:0]  mem_q [2**MEM_AW];
  logic [INIT_W-1:0]     init_idx_q;
  logic                  done_q;
  logic                  init_busy;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [REQ_PORTS-1:0]  ack;
  logic                  gnt_vld;
  logic [PTR_W-1:0]      gnt_port;
  int                    p;
  int                    gp;

  logic                  iss_vld, iss_inr;
  logic [ADDR_WIDTH-1:0] iss_idx;
  logic [INC_WIDTH-1:0]  iss_num;
  logic                  iss_clr;

  logic                  vld_p1_q, rd_p1_q, zero_p1_q, inr_p1_q, clr_p1_q;
  logic [ADDR_WIDTH-1:0] idx_p1_q;
  logic [INC_WIDTH-1:0]  num_p1_q;
  logic                  byp_p1, wr_p1;
  logic [CNT_WIDTH-1:0]  ram_p1, cur_p1, new_p1;

  logic                  wr_p2_q;
  logic [ADDR_WIDTH-1:0] idx_p2_q;
  logic [CNT_WIDTH-1:0]  val_p2_q;

  logic                  rvld_q;
  logic [CNT_WIDTH-1:0]  rdata_q;

  assign init_busy = int'(init_idx_q) < STAT_CNT;

  // Grant: a CPU read takes the slot, otherwise round-robin from the pointer.
  always_comb begin
    ack      = '0;
    gnt_vld  = 1'b0;
    gnt_port = '0;
    ptr_d    = ptr_q;
    p        = 0;
    if (done_q && !qStatREn) begin
      for (int k = 0; k < REQ_PORTS; k++) begin
        p = (int'(ptr_q) + k) % REQ_PORTS;
        if (!gnt_vld && qvUpdtReq[p]) begin
          gnt_vld  = 1'b1;
          gnt_port = PTR_W'(p);
        end
      end
    end
    if (gnt_vld) begin
      ack[gnt_port] = 1'b1;
      ptr_d = (int'(gnt_port) == REQ_PORTS - 1) ? '0 : gnt_port + 1'b1;
    end
  end

  assign qvUpdtAck = ack;
  assign gp        = int'(gnt_port);
  assign iss_vld   = qStatREn | gnt_vld;
  assign iss_idx   = qStatREn ? qvStatRAddr : qvUpdtIndex[gp*ADDR_WIDTH +: ADDR_WIDTH];
  assign iss_num   = qvUpdtNum[gp*INC_WIDTH +: INC_WIDTH];
  assign iss_clr   = qvUpdtClr[gp];
  assign iss_inr   = int'(iss_idx) < STAT_CNT;

  // Stage 1: read old value (bypassing the pending S2 write) and compute the new one.
  assign byp_p1 = wr_p2_q && (idx_p2_q == idx_p1_q);
  assign ram_p1 = mem_q[idx_p1_q[MEM_AW-1:0]];
  assign cur_p1 = (zero_p1_q || !inr_p1_q) ? '0 : (byp_p1 ? val_p2_q : ram_p1);
  assign new_p1 = rd_p1_q ? '0 : sat_add(cur_p1, num_p1_q, clr_p1_q);
  assign wr_p1  = vld_p1_q && inr_p1_q && !zero_p1_q && (!rd_p1_q || (RD_CLEAR != 0));

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      init_idx_q <= '0;
      done_q     <= 1'b0;
      ptr_q      <= '0;
      vld_p1_q   <= 1'b0;
      wr_p2_q    <= 1'b0;
      rvld_q     <= 1'b0;
      rdata_q    <= '0;
    end else begin
      if (init_busy) init_idx_q <= init_idx_q + 1'b1;
      done_q   <= done_q | (int'(init_idx_q) == STAT_CNT);
      ptr_q    <= ptr_d;
      vld_p1_q <= iss_vld;
      wr_p2_q  <= wr_p1;
      rvld_q   <= vld_p1_q & rd_p1_q;
      if (vld_p1_q && rd_p1_q) rdata_q <= cur_p1;
    end
  end

  always_ff @(posedge Clock) begin
    if (iss_vld) begin
      rd_p1_q   <= qStatREn;
      zero_p1_q <= qStatREn & ~done_q;
      inr_p1_q  <= iss_inr;
      idx_p1_q  <= iss_idx;
      num_p1_q  <= iss_num;
      clr_p1_q  <= iss_clr;
    end
    // Stage 2: registered write-back value.
    if (wr_p1) begin
      idx_p2_q <= idx_p1_q;
      val_p2_q <= new_p1;
    end
  end

  // The init sweep owns the write port until every counter has been zeroed.
  always_ff @(posedge Clock) begin
    if (init_busy)    mem_q[init_idx_q[MEM_AW-1:0]] <= '0;
    else if (wr_p2_q) mem_q[idx_p2_q[MEM_AW-1:0]]   <= val_p2_q;
  end

  assign qStatRValid = rvld_q;
  assign qvStatRData = rdata_q;
  assign qInitDone   = done_q;

endmodule

// File: tb/tb_stat_info_mem_mp.sv
// Scoreboard bench for stat_info_mem_mp: two instances (saturate+read-clear, wrap+plain read)
// driven with identical stimulus and compared against a sequential counter model.
module tb_stat_info_mem_mp;
  localparam int SC = 64;
  localparam int AW = 7;
  localparam int CW = 8;
  localparam int IW = 8;
  localparam int RP = 2;

  typedef struct packed { logic [AW-1:0] idx; logic [IW-1:0] num; logic clr; } op_t;
  typedef struct packed { int due; logic [CW-1:0] data; } exp_t;

  logic          Clock = 1'b0;
  logic          nReset = 1'b1;
  logic [RP-1:0] qvUpdtReq, qvUpdtClr;
  logic [RP*AW-1:0] qvUpdtIndex;
  logic [RP*IW-1:0] qvUpdtNum;
  logic          qStatREn;
  logic [AW-1:0] qvStatRAddr;
  logic [RP-1:0] ack_a, ack_b;
  logic          rv_a, rv_b, done_a, done_b;
  logic [CW-1:0] rd_a, rd_b;

  logic [CW-1:0] mem_a [SC];
  logic [CW-1:0] mem_b [SC];
  op_t  pq0[$], pq1[$];
  exp_t qa[$], qb[$];
  int   cyc = 0, since_rel = 0, ptr_m = 0;
  int   n_cmp = 0, n_bad = 0;

  always #5 Clock = ~Clock;

  stat_info_mem_mp #(.STAT_CNT(SC), .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .INC_WIDTH(IW),
                     .REQ_PORTS(RP), .SAT_MODE(1), .RD_CLEAR(1)) dut_a (
    .Clock(Clock), .nReset(nReset), .qvUpdtReq(qvUpdtReq), .qvUpdtIndex(qvUpdtIndex),
    .qvUpdtNum(qvUpdtNum), .qvUpdtClr(qvUpdtClr), .qvUpdtAck(ack_a), .qStatREn(qStatREn),
    .qvStatRAddr(qvStatRAddr), .qStatRValid(rv_a), .qvStatRData(rd_a), .qInitDone(done_a));

  stat_info_mem_mp #(.STAT_CNT(SC), .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .INC_WIDTH(IW),
                     .REQ_PORTS(RP), .SAT_MODE(0), .RD_CLEAR(0)) dut_b (
    .Clock(Clock), .nReset(nReset), .qvUpdtReq(qvUpdtReq), .qvUpdtIndex(qvUpdtIndex),
    .qvUpdtNum(qvUpdtNum), .qvUpdtClr(qvUpdtClr), .qvUpdtAck(ack_b), .qStatREn(qStatREn),
    .qvStatRAddr(qvStatRAddr), .qStatRValid(rv_b), .qvStatRData(rd_b), .qInitDone(done_b));

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp_v, cyc);
    end
  endtask

  function automatic logic [CW-1:0] f_upd(input logic [CW-1:0] old_v, input logic [IW-1:0] n,
                                          input logic c, input bit sat);
    logic [CW:0] s;
    s = {1'b0, old_v} + (CW + 1)'(n);
    if (c) return '0;
    if (sat && s[CW]) return '1;
    return s[CW-1:0];
  endfunction

  task automatic reset_model();
    foreach (mem_a[i]) begin mem_a[i] = '0; mem_b[i] = '0; end
    pq0.delete(); pq1.delete(); qa.delete(); qb.delete();
    ptr_m = 0;
    since_rel = 0;
  endtask

  task automatic push_op(input int port, input int idx, input int num, input bit clr);
    op_t o;
    o.idx = AW'(idx);
    o.num = IW'(num);
    o.clr = clr;
    if (port == 0) pq0.push_back(o);
    else           pq1.push_back(o);
  endtask

  task automatic apply_upd(input op_t o);
    if (int'(o.idx) < SC) begin
      mem_a[o.idx[5:0]] = f_upd(mem_a[o.idx[5:0]], o.num, o.clr, 1'b1);
      mem_b[o.idx[5:0]] = f_upd(mem_b[o.idx[5:0]], o.num, o.clr, 1'b0);
    end
  endtask

  // One clock: drive at edge+1, check grant at negedge, check read outputs at next edge+1.
  task automatic tick(input logic r_en, input logic [AW-1:0] r_addr);
    op_t o;
    exp_t e;
    int g;
    logic [RP-1:0] exp_ack;
    logic done_m;
    bit due;
    qStatREn    = r_en;
    qvStatRAddr = r_addr;
    qvUpdtReq   = '0;
    if (pq0.size() > 0) begin
      qvUpdtReq[0] = 1'b1; qvUpdtIndex[0 +: AW] = pq0[0].idx;
      qvUpdtNum[0 +: IW] = pq0[0].num; qvUpdtClr[0] = pq0[0].clr;
    end
    if (pq1.size() > 0) begin
      qvUpdtReq[1] = 1'b1; qvUpdtIndex[AW +: AW] = pq1[0].idx;
      qvUpdtNum[IW +: IW] = pq1[0].num; qvUpdtClr[1] = pq1[0].clr;
    end
    @(negedge Clock);
    done_m = nReset && (since_rel >= 65);
    chk_eq("init_done_a", 64'(done_a), 64'(done_m));
    chk_eq("init_done_b", 64'(done_b), 64'(done_m));
    g = -1;
    if (done_m && !r_en)
      for (int k = 0; k < RP; k++)
        if (g < 0 && qvUpdtReq[(ptr_m + k) % RP]) g = (ptr_m + k) % RP;
    exp_ack = '0;
    if (g >= 0) begin
      exp_ack[g] = 1'b1;
      ptr_m = (g + 1) % RP;
    end
    chk_eq("ack_a", 64'(ack_a), 64'(exp_ack));
    chk_eq("ack_b", 64'(ack_b), 64'(exp_ack));
    if (g == 0) begin o = pq0.pop_front(); apply_upd(o); end
    else if (g == 1) begin o = pq1.pop_front(); apply_upd(o); end
    if (r_en) begin
      e.due  = cyc + 2;
      e.data = (int'(r_addr) < SC) ? mem_a[r_addr[5:0]] : '0;
      qa.push_back(e);
      e.data = (int'(r_addr) < SC) ? mem_b[r_addr[5:0]] : '0;
      qb.push_back(e);
      if (int'(r_addr) < SC) mem_a[r_addr[5:0]] = '0;
    end
    @(posedge Clock);
    #1;
    cyc++;
    if (nReset) since_rel++;
    due = (qa.size() > 0) && (qa[0].due == cyc);
    if (due || rv_a) chk_eq("rvalid_a", 64'(rv_a), 64'(due));
    if (due) begin e = qa.pop_front(); chk_eq("rdata_a", 64'(rd_a), 64'(e.data)); end
    due = (qb.size() > 0) && (qb[0].due == cyc);
    if (due || rv_b) chk_eq("rvalid_b", 64'(rv_b), 64'(due));
    if (due) begin e = qb.pop_front(); chk_eq("rdata_b", 64'(rd_b), 64'(e.data)); end
  endtask

  task automatic drain(input int max_c, input int flush);
    int n = 0;
    while ((pq0.size() + pq1.size()) > 0 && n < max_c) begin
      tick(1'b0, '0);
      n++;
    end
    chk_eq("drain", 64'(pq0.size() + pq1.size()), 64'd0);
    repeat (flush) tick(1'b0, '0);
  endtask

  task automatic chk_idle(input string tag);
    chk_eq({tag, "_ack_a"}, 64'(ack_a), 64'd0);
    chk_eq({tag, "_rvalid_a"}, 64'(rv_a), 64'd0);
    chk_eq({tag, "_rdata_a"}, 64'(rd_a), 64'd0);
    chk_eq({tag, "_done_a"}, 64'(done_a), 64'd0);
    chk_eq({tag, "_ack_b"}, 64'(ack_b), 64'd0);
    chk_eq({tag, "_rvalid_b"}, 64'(rv_b), 64'd0);
    chk_eq({tag, "_rdata_b"}, 64'(rd_b), 64'd0);
    chk_eq({tag, "_done_b"}, 64'(done_b), 64'd0);
  endtask

  task automatic do_reset();
    nReset = 1'b0;
    reset_model();
    #1;
    chk_idle("midrst");
    tick(1'b0, '0);
    tick(1'b0, '0);
    nReset = 1'b1;
  endtask

  initial begin
    qStatREn = 1'b0; qvStatRAddr = '0; qvUpdtReq = '0;
    qvUpdtIndex = '0; qvUpdtNum = '0; qvUpdtClr = '0;
    reset_model();
    #2 nReset = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    chk_idle("rst");
    nReset = 1'b1;

    // Init sweep with reads during it, then every counter reads zero.
    for (int i = 0; i < 70; i++) tick(i == 3 || i == 64, AW'(i));
    for (int i = 0; i < SC; i++) tick(1'b1, AW'(i));
    repeat (3) tick(1'b0, '0);

    // Back-to-back accumulation through the bypass.
    repeat (4) push_op(0, 5, 3, 1'b0);
    drain(20, 0);
    tick(1'b1, AW'(5));
    repeat (3) tick(1'b0, '0);

    // Two ports streaming, read mid-stream.
    for (int k = 0; k < 6; k++) begin
      push_op(0, 10 + k, 1, 1'b0);
      push_op(1, 20 + k, 2, 1'b0);
    end
    repeat (3) tick(1'b0, '0);
    tick(1'b1, AW'(10));
    drain(30, 3);
    for (int k = 0; k < 3; k++) begin tick(1'b1, AW'(10 + k)); tick(1'b1, AW'(20 + k)); end
    repeat (3) tick(1'b0, '0);

    // Saturation vs wrap: 250 + 10.
    push_op(1, 30, 250, 1'b0);
    push_op(1, 30, 10, 1'b0);
    drain(10, 0);
    tick(1'b1, AW'(30));
    repeat (3) tick(1'b0, '0);

    // Read-clear with an update still in flight.
    push_op(0, 7, 9, 1'b0);
    tick(1'b0, '0);
    tick(1'b1, AW'(7));
    tick(1'b1, AW'(7));
    repeat (3) tick(1'b0, '0);

    // Clear, then an out-of-range update and read.
    push_op(0, 3, 100, 1'b0);
    push_op(0, 3, 0, 1'b1);
    drain(10, 0);
    tick(1'b1, AW'(3));
    push_op(1, 70, 5, 1'b0);
    drain(10, 0);
    tick(1'b1, AW'(70));
    for (int i = 0; i < SC; i++) tick(1'b1, AW'(i));
    repeat (3) tick(1'b0, '0);

    // Random mix of updates, clears, reads, out-of-range indexes.
    for (int i = 0; i < 300; i++) begin
      if (pq0.size() == 0 && $urandom_range(0, 1) == 1)
        push_op(0, $urandom_range(0, 71), $urandom_range(0, 255), $urandom_range(0, 7) == 0);
      if (pq1.size() == 0 && $urandom_range(0, 1) == 1)
        push_op(1, $urandom_range(0, 71), $urandom_range(0, 255), $urandom_range(0, 7) == 0);
      tick($urandom_range(0, 4) == 0, AW'($urandom_range(0, 71)));
    end
    drain(50, 3);

    // Reset pulse mid-stream restarts init and wipes the counters.
    push_op(0, 40, 7, 1'b0);
    push_op(1, 41, 8, 1'b0);
    tick(1'b0, '0);
    tick(1'b1, AW'(40));
    do_reset();
    for (int i = 0; i < 70; i++) tick(i == 10, AW'(40));
    for (int i = 38; i < 44; i++) tick(1'b1, AW'(i));
    repeat (3) tick(1'b0, '0);

    chk_eq("pending_a", 64'(qa.size()), 64'd0);
    chk_eq("pending_b", 64'(qb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
